run_sequencer: RTL and testbench

Top-level run controller for the program counter. Owns the PC's `init` line. Steps the core through its consecutive programs (three by default), one start/acknowledge cycle per program. For each program it records the cycle count and the final PC, and reports completion to the testbench or host through a done/ack handshake.

---
 rtl/run_seq_pkg.sv | 19 +
 rtl/run_cycle_counter.sv | 50 +++++
 rtl/run_sequencer.sv | 157 +++++++++++++++
 tb/tb_run_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_seq_pkg.sv
// run_seq_pkg: shared state encoding and default constants for the run
// sequencer and its cycle counter.
package run_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } run_state_t;

    localparam int unsigned DEF_NUM_PROGS   = 3;
    localparam int unsigned DEF_INIT_CYCLES = 2;
    localparam int unsigned DEF_CNT_W       = 16;
    localparam int unsigned DEF_WDOG_LIMIT  = 4000;
    localparam int unsigned PC_W            = 10;
    localparam int unsigned IDX_W           = 2;

endpackage

// File: rtl/run_cycle_counter.sv
// run_cycle_counter: CNT_W-wide saturating run counter with synchronous
// clear and enable. The limit_hit compare exists only when the watchdog
// is compiled in (macro RUN_SEQ_WATCHDOG_EN); otherwise it is tied low.
module run_cycle_counter
    import run_seq_pkg::*;
#(
    parameter int unsigned      CNT_W = DEF_CNT_W,
    parameter logic [CNT_W-1:0] LIMIT = '1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             limit_hit_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, increments stop at all-ones instead of wrapping
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

`ifdef RUN_SEQ_WATCHDOG_EN
    assign limit_hit_o = (cnt_q == LIMIT);
`else
    logic unused_limit;
    assign unused_limit = ^LIMIT;
    assign limit_hit_o  = 1'b0;
`endif

endmodule

// File: rtl/run_sequencer.sv
// run_sequencer: top-level run controller for the program counter. Owns the
// PC's init line, steps through NUM_PROGS programs with a done/ack handshake
// per program, and records cycle count and final PC of each run.
// Optional watchdog abort: define RUN_SEQ_WATCHDOG_EN.
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int unsigned      NUM_PROGS   = DEF_NUM_PROGS,
    parameter int unsigned      INIT_CYCLES = DEF_INIT_CYCLES,
    parameter int unsigned      CNT_W       = DEF_CNT_W,
    parameter logic [CNT_W-1:0] WDOG_LIMIT  = CNT_W'(DEF_WDOG_LIMIT)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic             ack,
    input  logic             halt,
    input  logic [PC_W-1:0]  pc,
    output logic             init,
    output logic             busy,
    output logic             done,
    output logic             seq_done,
    output logic [IDX_W-1:0] prog_idx,
    output logic [CNT_W-1:0] cycle_count,
    output logic [PC_W-1:0]  end_pc,
    output logic             timeout
);

    localparam int unsigned      IW        = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [IW-1:0]    INIT_LAST = IW'(INIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_PROGS - 1);

    run_state_t       state_q, state_d;
    logic [IW-1:0]    init_cnt_q, init_cnt_d;
    logic [CNT_W-1:0] run_cnt;
    logic             limit_hit;
    logic             last_prog;
    logic             run_end;

    logic             init_q, init_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             seq_done_q, seq_done_d;
    logic             timeout_q, timeout_d;
    logic [IDX_W-1:0] prog_idx_q, prog_idx_d;
    logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
    logic [PC_W-1:0]  end_pc_q, end_pc_d;

    assign last_prog = (prog_idx_q == IDX_LAST);
    assign run_end   = (state_q == ST_RUN) && (state_d == ST_DONE);

    // Run counter is held at zero throughout INIT so every program starts from 0
    run_cycle_counter #(
        .CNT_W (CNT_W),
        .LIMIT (WDOG_LIMIT)
    ) u_cnt (
        .clk_i       (CLK),
        .rst_ni      (RST_N),
        .clr_i       (state_q == ST_INIT),
        .en_i        ((state_q == ST_RUN) && !halt),
        .cnt_o       (run_cnt),
        .limit_hit_o (limit_hit)
    );

    // INIT dwell counter restarts from zero on every entry into INIT
    always_comb begin
        init_cnt_d = '0;
        if (state_q == ST_INIT) begin
            init_cnt_d = init_cnt_q + IW'(1);
        end
    end

    // State and dwell registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // Next state: each input is only looked at in the one state that cares
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_INIT;
            ST_INIT: if (init_cnt_q == INIT_LAST) state_d = ST_RUN;
            ST_RUN:  if (halt || limit_hit) state_d = ST_DONE;
            ST_DONE: if (ack) state_d = last_prog ? ST_IDLE : ST_INIT;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output next-values, decoded from the state being entered so they register cleanly
    always_comb begin
        init_d        = (state_d != ST_RUN);
        busy_d        = (state_d != ST_IDLE);
        done_d        = (state_d == ST_DONE);
        seq_done_d    = (state_q == ST_DONE) && ack && last_prog;
        prog_idx_d    = prog_idx_q;
        cycle_count_d = cycle_count_q;
        end_pc_d      = end_pc_q;
        timeout_d     = timeout_q;

        if ((state_q == ST_IDLE) && start) begin
            prog_idx_d = '0;
        end else if ((state_q == ST_DONE) && ack) begin
            prog_idx_d = last_prog ? '0 : prog_idx_q + IDX_W'(1);
        end

        if (run_end) begin
            cycle_count_d = run_cnt;
            end_pc_d      = pc;
`ifdef RUN_SEQ_WATCHDOG_EN
            // A halt on the same cycle as the limit is a normal finish
            timeout_d     = !halt;
`else
            timeout_d     = 1'b0;
`endif
        end
    end

    // Output registers; init sits high out of reset so the PC stays frozen
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            init_q        <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            seq_done_q    <= 1'b0;
            timeout_q     <= 1'b0;
            prog_idx_q    <= '0;
            cycle_count_q <= '0;
            end_pc_q      <= '0;
        end else begin
            init_q        <= init_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            seq_done_q    <= seq_done_d;
            timeout_q     <= timeout_d;
            prog_idx_q    <= prog_idx_d;
            cycle_count_q <= cycle_count_d;
            end_pc_q      <= end_pc_d;
        end
    end

    assign init        = init_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign seq_done    = seq_done_q;
    assign timeout     = timeout_q;
    assign prog_idx    = prog_idx_q;
    assign cycle_count = cycle_count_q;
    assign end_pc      = end_pc_q;

endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: directed bench for run_sequencer with a simple PC model
// (counts while init is low and not halted, halts at a chosen address) and
// a phase-level reference model compared against the DUT every cycle.
module tb_run_sequencer;

    localparam int          NP = 3;
    localparam int          IC = 2;
    localparam logic [15:0] WD = 16'd1000;

    logic        CLK   = 1'b0;
    logic        RST_N = 1'b1;
    logic        start = 1'b0;
    logic        ack   = 1'b0;
    logic        halt;
    logic [9:0]  pc;
    logic        init, busy, done, seq_done, timeout;
    logic [1:0]  prog_idx;
    logic [15:0] cycle_count;
    logic [9:0]  end_pc;

    logic [9:0]  pc_m    = '0;
    logic [9:0]  halt_at = 10'd168;
    logic        chk_en  = 1'b0;

    int total = 0;
    int bad   = 0;

    run_sequencer #(
        .NUM_PROGS   (NP),
        .INIT_CYCLES (IC),
        .CNT_W       (16),
        .WDOG_LIMIT  (WD)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .start       (start),
        .ack         (ack),
        .halt        (halt),
        .pc          (pc),
        .init        (init),
        .busy        (busy),
        .done        (done),
        .seq_done    (seq_done),
        .prog_idx    (prog_idx),
        .cycle_count (cycle_count),
        .end_pc      (end_pc),
        .timeout     (timeout)
    );

    always #5 CLK = ~CLK;

    // PC model: executes while init is low, stops on reaching its halt address
    assign pc   = pc_m;
    assign halt = (pc_m == halt_at);
    always @(posedge CLK) if (!init && !halt) pc_m <= pc_m + 10'd1;

    // Reference model: phase 0 idle, 1 init, 2 run, 3 done
    int          m_ph   = 0;
    int          m_left = 0;
    int          m_run  = 0;
    logic [1:0]  e_prog = '0;
    logic [15:0] e_cnt  = '0;
    logic [9:0]  e_pc   = '0;
    logic        e_to   = 1'b0;
    logic        e_seq  = 1'b0;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_ph <= 0; m_left <= 0; m_run <= 0;
            e_prog <= '0; e_cnt <= '0; e_pc <= '0; e_to <= 1'b0; e_seq <= 1'b0;
        end else begin
            e_seq <= 1'b0;
            case (m_ph)
                0: if (start) begin m_ph <= 1; m_left <= IC; e_prog <= '0; end
                1: begin
                    m_run <= 0;
                    if (m_left == 1) m_ph <= 2;
                    else m_left <= m_left - 1;
                end
                2: begin
                    if (halt) begin
                        m_ph <= 3; e_cnt <= m_run[15:0]; e_pc <= pc; e_to <= 1'b0;
                    end
`ifdef RUN_SEQ_WATCHDOG_EN
                    else if (m_run == int'(WD)) begin
                        m_ph <= 3; e_cnt <= WD; e_pc <= pc; e_to <= 1'b1;
                    end
`endif
                    else if (m_run < 65535) m_run <= m_run + 1;
                end
                default: if (ack) begin
                    if (int'(e_prog) == NP - 1) begin
                        m_ph <= 0; e_prog <= '0; e_seq <= 1'b1;
                    end else begin
                        m_ph <= 1; m_left <= IC; e_prog <= e_prog + 2'd1;
                    end
                end
            endcase
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the reference model
    always @(negedge CLK) begin
        if (chk_en) begin
            check("m_init",     32'(init),        32'(m_ph != 2));
            check("m_busy",     32'(busy),        32'(m_ph != 0));
            check("m_done",     32'(done),        32'(m_ph == 3));
            check("m_seq_done", 32'(seq_done),    32'(e_seq));
            check("m_prog_idx", 32'(prog_idx),    32'(e_prog));
            check("m_cycles",   32'(cycle_count), 32'(e_cnt));
            check("m_end_pc",   32'(end_pc),      32'(e_pc));
            check("m_timeout",  32'(timeout),     32'(e_to));
        end
    end

    // Wait (bounded) for done; report how many cycles init was low meanwhile
    task automatic run_prog(output int low);
        bit ok;
        low = 0;
        ok  = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            if (!init) low++;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_wait", 32'(ok), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(negedge CLK);
        ack = 1'b0;
    endtask

    int low;
    logic [9:0] base;

    initial begin
        // Reset with start pulsed while held
        #1 RST_N = 1'b0;
        chk_en = 1'b1;
        repeat (2) @(negedge CLK);
        pulse_start();
        check("rst_init", 32'(init), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_idx",  32'(prog_idx), 32'd0);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        check("idle_after_rst", 32'(busy), 32'd0);

        // Three programs halting at PC 168 / 365 / 590; the halting cycle
        // itself is a RUN cycle, so init is low one cycle longer than the count
        halt_at = 10'd168;
        pulse_start();
        run_prog(low);
        check("p0_cycles", 32'(cycle_count), 32'd168);
        check("p0_end_pc", 32'(end_pc), 32'd168);
        check("p0_idx",    32'(prog_idx), 32'd0);
        check("p0_low",    32'(low), 32'd169);

        halt_at = 10'd365;
        pulse_ack();
        run_prog(low);
        check("p1_cycles", 32'(cycle_count), 32'd197);
        check("p1_end_pc", 32'(end_pc), 32'd365);
        check("p1_idx",    32'(prog_idx), 32'd1);

        halt_at = 10'd590;
        pulse_ack();
        run_prog(low);
        check("p2_cycles", 32'(cycle_count), 32'd225);
        check("p2_end_pc", 32'(end_pc), 32'd590);
        check("p2_idx",    32'(prog_idx), 32'd2);

        pulse_ack();
        check("seq_pulse",  32'(seq_done), 32'd1);
        check("seq_idle",   32'(busy), 32'd0);
        check("seq_idx0",   32'(prog_idx), 32'd0);
        @(negedge CLK);
        check("seq_single", 32'(seq_done), 32'd0);

        // ack held high throughout; a stray start during RUN is ignored
        base    = pc_m;
        halt_at = base + 10'd10;
        ack     = 1'b1;
        pulse_start();
        repeat (3) @(negedge CLK);
        pulse_start();
        run_prog(low);
        check("h0_cycles", 32'(cycle_count), 32'd10);
        check("h0_idx",    32'(prog_idx), 32'd0);
        halt_at = base + 10'd30;
        run_prog(low);
        check("h1_cycles", 32'(cycle_count), 32'd20);
        check("h1_idx",    32'(prog_idx), 32'd1);
        halt_at = base + 10'd60;
        run_prog(low);
        check("h2_cycles", 32'(cycle_count), 32'd30);
        check("h2_idx",    32'(prog_idx), 32'd2);
        @(negedge CLK);
        check("h_seq_pulse", 32'(seq_done), 32'd1);
        check("h_idle",      32'(busy), 32'd0);
        @(negedge CLK);
        check("h_seq_once",  32'(seq_done), 32'd0);
        check("h_stay_idle", 32'(busy), 32'd0);
        ack = 1'b0;

        // Asynchronous reset in the middle of RUN
        halt_at = pc_m + 10'd500;
        pulse_start();
        repeat (20) @(negedge CLK);
        @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        check("arst_init",   32'(init), 32'd1);
        check("arst_busy",   32'(busy), 32'd0);
        check("arst_done",   32'(done), 32'd0);
        check("arst_idx",    32'(prog_idx), 32'd0);
        check("arst_cycles", 32'(cycle_count), 32'd0);
        check("arst_end_pc", 32'(end_pc), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        halt_at = pc_m + 10'd40;
        pulse_start();
        run_prog(low);
        check("r_cycles", 32'(cycle_count), 32'd40);
        check("r_end_pc", 32'(end_pc), 32'(halt_at));
        check("r_idx",    32'(prog_idx), 32'd0);

`ifdef RUN_SEQ_WATCHDOG_EN
        // Halt address placed out of reach so the watchdog ends program 1
        halt_at = pc_m - 10'd1;
        pulse_ack();
        run_prog(low);
        check("wd_timeout", 32'(timeout), 32'd1);
        check("wd_cycles",  32'(cycle_count), 32'(WD));
        check("wd_idx",     32'(prog_idx), 32'd1);
`else
        check("no_wd_timeout", 32'(timeout), 32'd0);
`endif

        repeat (2) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
